// File: rtl/pe_q_merge.sv
// pe_q_merge: buffers the two PE result streams in per-channel FIFOs and merges them,
// burst by burst with round-robin arbitration, onto one channel-tagged 64-bit stream.
module pe_q_merge #(
   parameter int unsigned DEPTH_LOG2 = 5,
   parameter int unsigned SLACK      = 4,
   parameter int unsigned BURST      = 16
) (
   input  logic        CLK,
   input  logic        SYS_RST,
   input  logic        PE_RST,
   input  logic [63:0] Q,
   input  logic        Q_VALID,
   output logic        Q_BP,
   input  logic [63:0] Q2,
   input  logic        Q2_VALID,
   output logic        Q2_BP,
   output logic [63:0] O,
   output logic        O_CH,
   output logic        O_VALID,
   input  logic        O_BP,
   output logic [31:0] CNT0,
   output logic [31:0] CNT1,
   output logic [1:0]  OVF
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned BW    = $clog2(BURST + 1);
   localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
   localparam logic [CW-1:0] BP_LVL    = CW'(DEPTH - SLACK);
   localparam logic [CW-1:0] ONE_LVL   = CW'(1);
   localparam logic [BW-1:0] BURST_LVL = BW'(BURST);

   typedef enum logic [1:0] {StIdle, StServe0, StServe1} state_t;

   state_t                     state_q;
   logic                       last_q;
   logic [BW-1:0]              burst_q;

   logic [63:0]                mem_q [2][DEPTH];
   logic [1:0][DEPTH_LOG2-1:0] wr_ptr_q;
   logic [1:0][DEPTH_LOG2-1:0] rd_ptr_q;
   logic [1:0][CW-1:0]         count_q;
   logic [1:0]                 bp_q;
   logic [1:0]                 ovf_q;

   logic [63:0]                o_q;
   logic                       o_ch_q;
   logic                       o_valid_q;
   logic [31:0]                cnt0_q;
   logic [31:0]                cnt1_q;

   logic [1:0][63:0]           in_data;
   logic [1:0][63:0]           head;
   logic [1:0]                 in_valid;
   logic [1:0]                 nonempty;
   logic [1:0]                 full;
   logic [1:0]                 pop;
   logic [1:0]                 wr;
   logic [1:0]                 drop;
   logic [1:0]                 last_word;
   logic                       serving;
   logic                       srv;

   // Per-channel FIFO status, pop/write decisions and head-of-queue read.
   always_comb begin
      in_valid   = {Q2_VALID, Q_VALID};
      in_data[0] = Q;
      in_data[1] = Q2;
      serving    = (state_q != StIdle);
      srv        = (state_q == StServe1);
      for (int i = 0; i < 2; i++) begin
         nonempty[i]  = (count_q[i] != '0);
         full[i]      = (count_q[i] == FULL_LVL);
         pop[i]       = serving && (srv == 1'(i)) && !O_BP && nonempty[i];
         // A pop frees its slot before the write lands, so full+pop still accepts.
         wr[i]        = in_valid[i] && (!full[i] || pop[i]);
         drop[i]      = in_valid[i] && full[i] && !pop[i];
         // This pop drains the FIFO, so the burst can end without an empty cycle.
         last_word[i] = (count_q[i] == ONE_LVL) && !wr[i];
         head[i]      = mem_q[i][rd_ptr_q[i]];
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         if (wr[i] && !PE_RST) begin
            mem_q[i][wr_ptr_q[i]] <= in_data[i];
         end
      end
   end

   // FIFO pointers, occupancy, registered backpressure and sticky overflow.
   always_ff @(posedge CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bp_q     <= '1;
         ovf_q    <= '0;
      end else if (PE_RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bp_q     <= '1;
         ovf_q    <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wr[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            case ({wr[i], pop[i]})
               2'b10:   count_q[i] <= count_q[i] + 1'b1;
               2'b01:   count_q[i] <= count_q[i] - 1'b1;
               default: count_q[i] <= count_q[i];
            endcase
            // Free entries <= SLACK, judged on occupancy before this edge.
            bp_q[i] <= (count_q[i] >= BP_LVL);
            if (drop[i]) ovf_q[i] <= 1'b1;
         end
      end
   end

   // Arbiter FSM with registered output word, channel tag and forward counters.
   always_ff @(posedge CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         burst_q   <= '0;
         o_q       <= '0;
         o_ch_q    <= 1'b0;
         o_valid_q <= 1'b0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else if (PE_RST) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         burst_q   <= '0;
         o_q       <= '0;
         o_ch_q    <= 1'b0;
         o_valid_q <= 1'b0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         o_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               burst_q <= '0;
               if (nonempty == 2'b11) begin
                  state_q <= last_q ? StServe0 : StServe1;
               end else if (nonempty[0]) begin
                  state_q <= StServe0;
               end else if (nonempty[1]) begin
                  state_q <= StServe1;
               end
            end
            StServe0, StServe1: begin
               if (|pop) begin
                  burst_q   <= burst_q + 1'b1;
                  o_q       <= head[srv];
                  o_ch_q    <= srv;
                  o_valid_q <= 1'b1;
                  if (srv) cnt1_q <= cnt1_q + 32'd1;
                  else     cnt0_q <= cnt0_q + 32'd1;
                  if ((burst_q + 1'b1 == BURST_LVL) || last_word[srv]) begin
                     state_q <= StIdle;
                     last_q  <= srv;
                  end
               end else if (!nonempty[srv]) begin
                  state_q <= StIdle;
                  last_q  <= srv;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign Q_BP    = bp_q[0] | PE_RST;
   assign Q2_BP   = bp_q[1] | PE_RST;
   assign O       = o_q;
   assign O_CH    = o_ch_q;
   assign O_VALID = o_valid_q;
   assign CNT0    = cnt0_q;
   assign CNT1    = cnt1_q;
   assign OVF     = ovf_q;

endmodule

// File: doc/pe_q_merge.md
Name: pe_q_merge

Overview:
- Downstream stage of the PE. Consumes both PE result streams (Q/Q_VALID/Q_BP and Q2/Q2_VALID/Q2_BP).
- Buffers each stream in its own FIFO and merges them, burst by burst with round-robin arbitration, onto one 64-bit output stream towards the host/link side.
- Tags every output word with its source channel.
- Applies the codebase VALID/BP flow control on both sides.

Parameters:
- DEPTH_LOG2, 5: log2 of per-channel FIFO depth (32 words).
- SLACK, 4: words the PE may still issue after it sees BP; also the free-entry threshold for raising BP.
- BURST, 16: maximum words granted to one channel per arbitration turn.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- SYS_RST  in  1  asynchronous active-low reset.
- PE_RST  in  1  synchronous active-high soft reset of the PE region.
- Q  in  64  PE channel-0 data.
- Q_VALID  in  1  channel-0 word present this cycle.
- Q_BP  out  1  backpressure to PE channel 0.
- Q2  in  64  PE channel-1 data.
- Q2_VALID  in  1  channel-1 word present this cycle.
- Q2_BP  out  1  backpressure to PE channel 1.
- O  out  64  merged output data.
- O_CH  out  1  source channel of O (0 = Q, 1 = Q2).
- O_VALID  out  1  O/O_CH valid this cycle.
- O_BP  in  1  backpressure from the consumer.
- CNT0  out  32  channel-0 words forwarded (wraps at 2^32).
- CNT1  out  32  channel-1 words forwarded (wraps at 2^32).
- OVF  out  2  sticky per-channel overflow flags (bit0 = channel 0).

Behaviour:
- Reset (SYS_RST low, asynchronous):
  - O=0, O_CH=0, O_VALID=0, CNT0=CNT1=0, OVF=0.
  - Q_BP=Q2_BP=1, FIFOs empty, state IDLE, last-served pointer = 1 (so channel 0 wins first).
- PE_RST high at an edge:
  - Same clearing as SYS_RST.
  - Q_BP/Q2_BP held 1 while PE_RST is high.
  - PE_RST wins over all simultaneous writes and pops.
- Input side:
  - A word is written when VALID=1 at an edge.
  - No per-word handshake; BP is advisory, with up to SLACK words of slack.
  - Q_BP is registered: it is 1 on the cycle after the FIFO free count is at or below SLACK, and falls on the cycle after the free count rises above SLACK.
  - Write into a full FIFO: the word is dropped, the corresponding OVF bit is set and stays set until reset; FIFO contents are unchanged.
  - Simultaneous write and pop on the same FIFO are both legal, including when full (the pop frees the slot first) and when empty (the word may not be popped in the same cycle).
- Arbiter FSM, states IDLE, SERVE0, SERVE1:
  - IDLE: if both FIFOs are non-empty, grant the channel not last served. Otherwise grant whichever is non-empty. Stay in IDLE if both are empty.
  - The grant takes effect at the next edge, which also clears the burst counter. IDLE costs exactly one cycle.
  - SERVEx: pop when O_BP=0 and FIFOx is non-empty at the edge. Each pop increments the burst count.
  - SERVEx -> IDLE when the burst count reaches BURST, or FIFOx is empty at the edge. Last-served is updated to x.
  - O_BP high in SERVEx holds the state and does not advance the burst count.
- Output:
  - Registered. A pop at edge k drives O, O_CH and O_VALID=1 during cycle k+1; otherwise O_VALID=0. O keeps its last value when O_VALID is 0.
  - If O_BP is sampled 1 at edge k, O_VALID is 0 in cycle k+1, so no words are issued after BP is observed.
  - Sustained throughput is 1 word/cycle within a burst.
- Counters: CNT0/CNT1 increment on each pop from their channel; 0xFFFFFFFF wraps to 0.
- Ordering: words within a channel leave in arrival order. There is no ordering guarantee across channels.

Test Plan:
- Reset: SYS_RST low mid-burst -> all outputs take their reset values immediately. After release, Q_BP falls one cycle after the first edge and no stale words appear.
- Single channel: 5 words 0x1..0x5 on Q, O_BP=0 -> O=0x1..0x5 on consecutive cycles with O_CH=0, first word 3 cycles after the first Q_VALID; CNT0=5.
- Round-robin: 40 words preloaded on each channel (Q_BP honoured) -> output bursts of 16/16/16/16/8/8 words with O_CH 0,1,0,1,0,1 and one idle cycle between bursts.
- Backpressure: O_BP high for 10 cycles mid-burst -> O_VALID=0 from the cycle after O_BP is sampled; output resumes in order with no loss or duplicates; burst boundaries are unchanged.
- Overflow: hold Q_VALID=1 while ignoring Q_BP, with O_BP=1 -> Q_BP=1 once 4 entries are free; 32 words stored; word 33 dropped; OVF=2'b01; releasing O_BP yields exactly words 1..32.
- Soft reset: PE_RST for one cycle with both FIFOs half full -> FIFOs empty, counters 0, OVF=0, O_VALID=0 next cycle; Q_BP=1 during PE_RST and 0 one cycle after.
